// File: rtl/grid_loader_if.sv
// ============================================================================
// grid_loader_if : row handshake and seed hand-off bundle for grid_loader
// Revision 1.0
// ============================================================================
`default_nettype none

interface grid_loader_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int IDX_W = $clog2(ROWS) + 1;
  localparam int CNT_W = $clog2(ROWS * COLS) + 1;

  logic                   row_valid;
  logic [COLS-1:0]        row_data;
  logic                   row_ready;
  logic                   clear;
  logic [ROWS*COLS-1:0]   seed;
  logic                   seed_valid;
  logic                   seed_ack;
  logic [IDX_W-1:0]       row_idx;
  logic [CNT_W-1:0]       live_count;

  // The master is the row source and seed consumer; the loader is the slave.
  modport master (
    output row_valid, row_data, clear, seed_ack,
    input  row_ready, seed, seed_valid, row_idx, live_count
  );

  modport slave (
    input  row_valid, row_data, clear, seed_ack,
    output row_ready, seed, seed_valid, row_idx, live_count
  );
endinterface

`default_nettype wire

// File: rtl/grid_loader.sv
// ============================================================================
// grid_loader : assembles ROWS row words into one seed, holds it until acked
// Revision 1.0
// ============================================================================
`default_nettype none

module grid_loader #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  wire          clk,
  input  wire          reset,
  grid_loader_if.slave bus
);
  localparam int IDX_W = $clog2(ROWS) + 1;
  localparam int CNT_W = $clog2(ROWS * COLS) + 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ROWS*COLS-1:0] seed_q, seed_d;
  logic                 seed_valid_q, seed_valid_d;
  logic                 row_ready_q, row_ready_d;
  logic [IDX_W-1:0]     row_idx_q, row_idx_d;
  logic [CNT_W-1:0]     live_count_q, live_count_d;
  logic                 transfer;

  function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int c = 0; c < COLS; c++) begin
      n = n + CNT_W'(v[c]);
    end
    return n;
  endfunction

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    seed_valid_d = seed_valid_q;
    row_ready_d  = row_ready_q;
    row_idx_d    = row_idx_q;
    live_count_d = live_count_q;
    // row_ready_q is low in HOLD and in the first cycle out of reset.
    transfer     = (state_q == FILL) && bus.row_valid && row_ready_q;

    if (bus.clear) begin
      state_d      = FILL;
      seed_d       = '0;
      seed_valid_d = 1'b0;
      row_ready_d  = 1'b1;
      row_idx_d    = '0;
      live_count_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          row_ready_d  = 1'b1;
          seed_valid_d = 1'b0;
          if (transfer) begin
            for (int r = 0; r < ROWS; r++) begin
              if (row_idx_q == IDX_W'(r)) begin
                seed_d[r*COLS +: COLS] = bus.row_data;
              end
            end
            row_idx_d    = row_idx_q + IDX_W'(1);
            live_count_d = live_count_q + popcount(bus.row_data);
            // Closing on the last row keeps a source with row_valid stuck high from over-filling.
            if (row_idx_q == IDX_W'(ROWS - 1)) begin
              state_d      = HOLD;
              row_ready_d  = 1'b0;
              seed_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          row_ready_d = 1'b0;
          if (bus.seed_ack) begin
            state_d      = FILL;
            seed_valid_d = 1'b0;
            row_ready_d  = 1'b1;
            row_idx_d    = '0;
            live_count_d = '0;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      row_ready_q  <= 1'b0;
      row_idx_q    <= '0;
      live_count_q <= '0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      seed_valid_q <= seed_valid_d;
      row_ready_q  <= row_ready_d;
      row_idx_q    <= row_idx_d;
      live_count_q <= live_count_d;
    end
  end

  assign bus.seed       = seed_q;
  assign bus.seed_valid = seed_valid_q;
  assign bus.row_ready  = row_ready_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.live_count = live_count_q;
endmodule

`default_nettype wire

// File: tb/tb_grid_loader.sv
// ============================================================================
// tb_grid_loader : directed vectors and corner sequences for grid_loader
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_grid_loader;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  grid_loader_if #(.ROWS(8), .COLS(8)) bus ();

  grid_loader #(.ROWS(8), .COLS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [7:0]  d;
    logic        clr;
    logic        ack;
    logic [63:0] seed;
    logic        v;
    logic        rdy;
    logic [3:0]  idx;
    logic [6:0]  cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] es, input logic ev,
                         input logic er, input logic [3:0] ei, input logic [6:0] ec);
    chk({tag, ".seed"},       bus.seed,               es);
    chk({tag, ".seed_valid"}, 64'(bus.seed_valid),    64'(ev));
    chk({tag, ".row_ready"},  64'(bus.row_ready),     64'(er));
    chk({tag, ".row_idx"},    64'(bus.row_idx),       64'(ei));
    chk({tag, ".live_count"}, 64'(bus.live_count),    64'(ec));
  endtask

  task automatic step(input logic rv, input logic [7:0] d, input logic clr, input logic ack,
                      input logic [63:0] es, input logic ev, input logic er,
                      input logic [3:0] ei, input logic [6:0] ec, input string tag);
    @(negedge clk);
    bus.row_valid = rv;
    bus.row_data  = d;
    bus.clear     = clr;
    bus.seed_ack  = ack;
    @(posedge clk);
    #1;
    chk_all(tag, es, ev, er, ei, ec);
  endtask

  initial begin
    logic [63:0] ms;
    int          acc;
    int          cum;
    logic [7:0]  rd;

    checks = 0;
    errors = 0;
    reset         = 1'b0;
    bus.row_valid = 1'b1;
    bus.row_data  = 8'hFF;
    bus.clear     = 1'b0;
    bus.seed_ack  = 1'b0;

    // Glider load, HOLD ignores rows, ack, refill with 8'h81, ack in FILL ignored.
    tbl[0]  = '{1'b1, 8'h02, 1'b0, 1'b0, 64'h0000_0000_0000_0002, 1'b0, 1'b1, 4'd1, 7'd1};
    tbl[1]  = '{1'b1, 8'h04, 1'b0, 1'b0, 64'h0000_0000_0000_0402, 1'b0, 1'b1, 4'd2, 7'd2};
    tbl[2]  = '{1'b1, 8'h07, 1'b0, 1'b0, 64'h0000_0000_0007_0402, 1'b0, 1'b1, 4'd3, 7'd5};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 64'h0000_0000_0007_0402, 1'b0, 1'b1, 4'd4, 7'd5};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 64'h0000_0000_0007_0402, 1'b0, 1'b1, 4'd5, 7'd5};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 64'h0000_0000_0007_0402, 1'b0, 1'b1, 4'd6, 7'd5};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 64'h0000_0000_0007_0402, 1'b0, 1'b1, 4'd7, 7'd5};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 64'h0000_0000_0007_0402, 1'b1, 1'b0, 4'd8, 7'd5};
    tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 64'h0000_0000_0007_0402, 1'b1, 1'b0, 4'd8, 7'd5};
    tbl[9]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 64'h0000_0000_0007_0402, 1'b0, 1'b1, 4'd0, 7'd0};
    tbl[10] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h0000_0000_0007_0481, 1'b0, 1'b1, 4'd1, 7'd2};
    tbl[11] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h0000_0000_0007_8181, 1'b0, 1'b1, 4'd2, 7'd4};
    tbl[12] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h0000_0000_0081_8181, 1'b0, 1'b1, 4'd3, 7'd6};
    tbl[13] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h0000_0000_8181_8181, 1'b0, 1'b1, 4'd4, 7'd8};
    tbl[14] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h0000_0081_8181_8181, 1'b0, 1'b1, 4'd5, 7'd10};
    tbl[15] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h0000_8181_8181_8181, 1'b0, 1'b1, 4'd6, 7'd12};
    tbl[16] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h0081_8181_8181_8181, 1'b0, 1'b1, 4'd7, 7'd14};
    tbl[17] = '{1'b1, 8'h81, 1'b0, 1'b0, 64'h8181_8181_8181_8181, 1'b1, 1'b0, 4'd8, 7'd16};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 64'h8181_8181_8181_8181, 1'b0, 1'b1, 4'd0, 7'd0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 64'h8181_8181_8181_8181, 1'b0, 1'b1, 4'd0, 7'd0};

    // Reset held with row_valid high: everything stays zero.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 64'h0, 1'b0, 1'b0, 4'd0, 7'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("release", 64'h0, 1'b0, 1'b1, 4'd0, 7'd0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rv, tbl[i].d, tbl[i].clr, tbl[i].ack, tbl[i].seed, tbl[i].v,
           tbl[i].rdy, tbl[i].idx, tbl[i].cnt, $sformatf("vec%0d", i));
    end

    // Stalled source of 8'hFF rows, then row_valid stuck high in HOLD.
    ms  = 64'h8181_8181_8181_8181;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i % 2) == 0 && acc < 8) begin
        ms[acc*8 +: 8] = 8'hFF;
        acc++;
      end
      step(((i % 2) == 0), 8'hFF, 1'b0, 1'b0, ms, (acc == 8), (acc != 8),
           4'(acc), 7'(acc * 8), $sformatf("stall%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd8, 7'd64,
           $sformatf("hold%0d", i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'd0, 7'd0, "ack2");

    // Clear mid-fill drops the simultaneous row.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 8'hFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'(i), 7'(i * 8),
           $sformatf("pre_clr%0d", i));
    end
    step(1'b1, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 4'd0, 7'd0, "clear_fill");

    ms  = 64'h0;
    cum = 0;
    for (int k = 0; k < 8; k++) begin
      rd = 8'(k + 1);
      ms[k*8 +: 8] = rd;
      cum += $countones(rd);
      step(1'b1, rd, 1'b0, 1'b0, ms, (k == 7), (k != 7), 4'(k + 1), 7'(cum),
           $sformatf("reload%0d", k));
    end
    chk("reload.final_seed", bus.seed, 64'h0807_0605_0403_0201);

    // Clear in HOLD wins over a simultaneous ack.
    step(1'b1, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0, 1'b1, 4'd0, 7'd0, "clear_hold");

    ms = 64'h0;
    for (int k = 0; k < 8; k++) begin
      ms[k*8 +: 8] = 8'h55;
      step(1'b1, 8'h55, 1'b0, 1'b0, ms, (k == 7), (k != 7), 4'(k + 1), 7'((k + 1) * 4),
           $sformatf("fill55_%0d", k));
    end

    // Asynchronous reset between edges while holding a seed.
    @(negedge clk);
    bus.row_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 64'h0, 1'b0, 1'b0, 4'd0, 7'd0);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/grid_loader.md
# grid_loader

Row-serial seed loader for the 8x8 Game of Life core. It accepts one grid row per handshake from an external source (host bench, UART front-end, pattern ROM) and assembles rows into the 64-bit seed word. Row r lands in `seed[8r+7:8r]`, the same packing the simulator uses when it prints the grid a row at a time. Once all rows are in, it presents the complete seed with a valid flag and a live-cell count, and holds both until the FSM consumes them.

## Interface
Parameters:
- `ROWS`, 8, number of grid rows per seed.
- `COLS`, 8, cells per row (row word width); seed width is ROWS*COLS.

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low reset (low = asserted).
- `row_valid`  in  1  source presents a row on `row_data`.
- `row_data`  in  COLS  row contents; bit c = cell (r,c), 1 = live.
- `row_ready`  out  1  loader accepts a row this cycle.
- `clear`  in  1  synchronous abort; discard the partial/held seed and restart.
- `seed`  out  ROWS*COLS  assembled grid, row r at bits [COLS*r+COLS-1 : COLS*r].
- `seed_valid`  out  1  seed complete and stable.
- `seed_ack`  in  1  consumer takes the seed (sampled only while `seed_valid`=1).
- `row_idx`  out  $clog2(ROWS)+1  rows accepted into the current seed (0..ROWS).
- `live_count`  out  $clog2(ROWS*COLS)+1  popcount of rows accepted so far (0..64 default).

## Operation
- Two states: FILL and HOLD. Reset enters FILL.
- Reset values: `seed`=0, `seed_valid`=0, `row_ready`=0, `row_idx`=0, `live_count`=0.
- All outputs are registered.
- `row_ready` rises on the first rising edge after reset deasserts.
- FILL:
  - `row_ready`=1, `seed_valid`=0.
  - A transfer occurs on any edge where `row_valid`&&`row_ready`.
  - On a transfer: write `row_data` into slot `row_idx`, increment `row_idx`, and add popcount(`row_data`) to `live_count`.
  - Other seed slots hold their value.
- FILL->HOLD: on the transfer with `row_idx`==ROWS-1.
  - Same edge: `row_ready`<=0, `seed_valid`<=1, `row_idx`<=ROWS.
- HOLD:
  - `row_ready`=0; `row_valid` is ignored.
  - `seed` and `live_count` stay frozen.
  - `seed_ack`=1 -> FILL. Same edge: `seed_valid`<=0, `row_ready`<=1, `row_idx`<=0, `live_count`<=0.
  - `seed` keeps its old contents and is overwritten slot by slot during the next fill.
- `seed_ack` while in FILL: ignored.
- `clear` has priority over everything else. From either state, on the edge it is high:
  - next state FILL;
  - `seed`<=0, `row_idx`<=0, `live_count`<=0, `seed_valid`<=0, `row_ready`<=1;
  - any row transfer or `seed_ack` on that same edge is discarded.
- Async reset mid-fill or mid-hold: all outputs go to their reset values immediately, with no dependence on the clock.
- Width rules:
  - `row_idx` never exceeds ROWS.
  - `live_count` is wide enough for ROWS*COLS and never wraps.

## Timing
- Throughput: 1 row per cycle when `row_valid` is held high.
- Fill latency: the first row is accepted on edge E1. With back-to-back rows, `seed_valid` is high after edge E8 (default).
- Minimum period per seed: 9 cycles (8 fill + 1 ack cycle).
  - `seed_ack` high in the first HOLD cycle re-opens `row_ready` one edge later.
- `row_ready` drops on the same edge that accepts the last row. A source holding `row_valid` high therefore cannot over-fill.
- `seed` is stable for the entire interval `seed_valid`=1. The FSM may load it directly into `flopenr`.

## Test plan
- Reset release:
  - While `reset`=0: all outputs are 0.
  - First edge after release: `row_ready`=1.
  - `row_valid` is held high during reset; no row is accepted until after release.
- Glider load:
  - Stimulus: rows 8'h02, 8'h04, 8'h07, then five 8'h00, back-to-back.
  - After edge 8: `seed_valid`=1, `seed`=64'h0000_0000_0007_0402, `live_count`=5, `row_idx`=8, `row_ready`=0.
- Stalled source with hold:
  - Stimulus: `row_valid` toggles every other cycle, all rows 8'hFF; keep `row_valid` high after the last row.
  - `seed_valid` rises only after the 8th accepted row.
  - `seed`=64'hFFFF_FFFF_FFFF_FFFF, `live_count`=64 (no wrap).
  - No extra transfer occurs while in HOLD.
- Ack and refill:
  - `seed_ack` pulses one cycle in HOLD -> next cycle `seed_valid`=0, `row_ready`=1, `row_idx`=0, `live_count`=0.
  - Second pattern of all 8'h81 rows -> `seed`=64'h8181_8181_8181_8181, `live_count`=16.
- Clear mid-fill:
  - After 3 rows of 8'hFF, assert `clear` together with `row_valid` -> `seed`=0, `row_idx`=0, `live_count`=0; the simultaneous row is dropped.
  - A subsequent full load completes normally.
- Async reset mid-hold:
  - Drop `reset` between clock edges while `seed_valid`=1 -> `seed_valid`, `seed` and `row_ready` go to 0 before the next edge.
